// File: rtl/cache_sim_pkg.sv
// Shared cache-simulator definitions: trace command codes, one-hot op indices,
// the default address width and the command legality / decode helpers.
package cache_sim_pkg;

    localparam int ADDR_W_DEFAULT = 64;

    localparam logic [3:0] CMD_RD_DATA = 4'd0;
    localparam logic [3:0] CMD_WR_DATA = 4'd1;
    localparam logic [3:0] CMD_IFETCH  = 4'd2;
    localparam logic [3:0] CMD_INVAL   = 4'd3;
    localparam logic [3:0] CMD_SNOOP   = 4'd4;
    localparam logic [3:0] CMD_CLEAR   = 4'd8;
    localparam logic [3:0] CMD_PRINT   = 4'd9;

    localparam int OP_RD_DATA = 0;
    localparam int OP_WR_DATA = 1;
    localparam int OP_IFETCH  = 2;
    localparam int OP_INVAL   = 3;
    localparam int OP_SNOOP   = 4;
    localparam int OP_CLEAR   = 5;
    localparam int OP_PRINT   = 6;
    localparam int OP_W       = 7;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_RD_DATA, CMD_WR_DATA, CMD_IFETCH, CMD_INVAL,
            CMD_SNOOP, CMD_CLEAR, CMD_PRINT: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic [OP_W-1:0] cmd_to_op(input logic [3:0] cmd);
        logic [OP_W-1:0] op;
        op = '0;
        case (cmd)
            CMD_RD_DATA: op[OP_RD_DATA] = 1'b1;
            CMD_WR_DATA: op[OP_WR_DATA] = 1'b1;
            CMD_IFETCH:  op[OP_IFETCH]  = 1'b1;
            CMD_INVAL:   op[OP_INVAL]   = 1'b1;
            CMD_SNOOP:   op[OP_SNOOP]   = 1'b1;
            CMD_CLEAR:   op[OP_CLEAR]   = 1'b1;
            CMD_PRINT:   op[OP_PRINT]   = 1'b1;
            default:     op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic synchronous FIFO with a registered first-word-fall-through head:
// dout always shows the oldest entry and holds its last value once empty.
module cmd_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             push_ok;
    logic             pop_ok;
    logic [PTR_W-1:0] rd_ptr_inc;

    assign full       = (level_reg == LVL_W'(DEPTH));
    assign empty      = (level_reg == '0);
    assign push_ok    = push && !full;
    assign pop_ok     = pop && !empty;
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign dout       = dout_reg;
    assign level      = level_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            // The head register is refilled from the incoming word when it
            // would otherwise be the only entry left, else from the next slot.
            if (push_ok && (empty || (pop_ok && level_reg == LVL_W'(1)))) begin
                dout_reg <= din;
            end else if (pop_ok && level_reg > LVL_W'(1)) begin
                dout_reg <= mem[rd_ptr_inc];
            end
        end
    end

endmodule

// File: rtl/trace_cmd_buffer.sv
// Trace command validator/buffer ahead of the cache core: filters illegal codes,
// queues legal ones, decodes one-hot ops and raises done once the trace drains.
// Optional per-op pop statistics are enabled by defining TRACE_CMD_STATS_EN.
module trace_cmd_buffer
    import cache_sim_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_command,
    input  logic [ADDR_W-1:0]        in_address,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_command,
    output logic [ADDR_W-1:0]        out_address,
    output logic [OP_W-1:0]          out_op,
    output logic                     done,
    output logic [CNT_W-1:0]         illegal_count,
`ifdef TRACE_CMD_STATS_EN
    output logic [OP_W*CNT_W-1:0]    op_count,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int FW = 4 + ADDR_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              in_legal;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] store_addr;
    logic [FW-1:0]     head;
    logic [CNT_W-1:0]  illegal_count_reg;
    logic              eot_reg;
    logic [1:0]        state_reg;
    logic [1:0]        state_next;

    assign in_legal   = is_legal_cmd(in_command);
    assign accept     = in_valid && in_ready;
    assign push       = accept && in_legal;
    assign store_addr = (in_command == CMD_CLEAR || in_command == CMD_PRINT) ? '0 : in_address;

    cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({in_command, store_addr}),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .level (level)
    );

    assign in_ready      = !fifo_full;
    assign out_valid     = !fifo_empty;
    assign pop           = out_valid && out_ready;
    assign out_command   = head[FW-1 -: 4];
    assign out_address   = head[ADDR_W-1:0];
    assign out_op        = out_valid ? cmd_to_op(out_command) : '0;
    assign illegal_count = illegal_count_reg;
    assign done          = (state_reg == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count_reg <= '0;
        end else if (accept && !in_legal && illegal_count_reg != '1) begin
            illegal_count_reg <= illegal_count_reg + 1'b1;
        end
    end

    // A push in the same cycle as in_last is already counted in level by the
    // time eot_reg is visible, so it holds off done until it is popped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (eot_reg && fifo_empty)
                    state_next = ST_DONE;
                else if (!fifo_empty)
                    state_next = eot_reg ? ST_DRAIN : ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (fifo_empty)
                    state_next = eot_reg ? ST_DONE : ST_IDLE;
                else if (eot_reg)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty)
                    state_next = ST_DONE;
            end
            ST_DONE:  state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eot_reg   <= 1'b0;
            state_reg <= ST_IDLE;
        end else begin
            if (in_last)
                eot_reg <= 1'b1;
            state_reg <= state_next;
        end
    end

`ifdef TRACE_CMD_STATS_EN
    generate
        for (genvar gi = 0; gi < OP_W; gi++) begin : g_op_count
            logic [CNT_W-1:0] count_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (pop && out_op[gi] && count_reg != '1) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
            assign op_count[gi*CNT_W +: CNT_W] = count_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_trace_cmd_buffer.sv
// Self-checking bench for trace_cmd_buffer: directed steps plus a random phase,
// compared every cycle against a queue-based reference model.
module tb_trace_cmd_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_command;
    logic [63:0] in_address;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_command;
    logic [63:0] out_address;
    logic [6:0]  out_op;
    logic        done;
    logic [15:0] illegal_count;
    logic [3:0]  level;
`ifdef TRACE_CMD_STATS_EN
    logic [7*16-1:0] op_count;
`endif

    trace_cmd_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_command    (in_command),
        .in_address    (in_address),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_command   (out_command),
        .out_address   (out_address),
        .out_op        (out_op),
        .done          (done),
        .illegal_count (illegal_count),
`ifdef TRACE_CMD_STATS_EN
        .op_count      (op_count),
`endif
        .level         (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [63:0] a;
    } ent_t;

    ent_t        q[$];
    int unsigned ill_m;
    bit          eot_m;
    bit          done_m;
    logic [3:0]  last_c;
    logic [63:0] last_a;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [6:0] exp_op(input logic [3:0] c);
        case (c)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b0000010;
            4'd2:    return 7'b0000100;
            4'd3:    return 7'b0001000;
            4'd4:    return 7'b0010000;
            4'd8:    return 7'b0100000;
            4'd9:    return 7'b1000000;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] c);
        return (c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9});
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ill_m  = 0;
        eot_m  = 0;
        done_m = 0;
        last_c = '0;
        last_a = '0;
    endtask

    task automatic check_all(input string ph);
        logic [3:0]  ec;
        logic [63:0] ea;
        logic [6:0]  eo;
        if (q.size() > 0) begin
            ec = q[0].c;
            ea = q[0].a;
            eo = exp_op(q[0].c);
        end else begin
            ec = last_c;
            ea = last_a;
            eo = '0;
        end
        chk({ph, ".in_ready"},      64'(in_ready),      64'(q.size() < DEPTH));
        chk({ph, ".out_valid"},     64'(out_valid),     64'(q.size() > 0));
        chk({ph, ".out_op"},        64'(out_op),        64'(eo));
        chk({ph, ".out_command"},   64'(out_command),   64'(ec));
        chk({ph, ".out_address"},   out_address,        ea);
        chk({ph, ".done"},          64'(done),          64'(done_m));
        chk({ph, ".illegal_count"}, 64'(illegal_count), 64'(ill_m));
        chk({ph, ".level"},         64'(level),         64'(q.size()));
    endtask

    // Check at the current (negedge) point, then advance one clock and update the model.
    task automatic tick(input string ph);
        bit   do_pop;
        bit   do_acc;
        bit   done_nx;
        ent_t e;
        check_all(ph);
        do_pop  = out_ready && (q.size() > 0);
        do_acc  = in_valid && (q.size() < DEPTH);
        done_nx = done_m || (eot_m && q.size() == 0);
        @(posedge clk);
        if (do_pop) begin
            $display("%s pop cmd=%0d addr=%0h", ph, q[0].c, q[0].a);
            void'(q.pop_front());
        end
        if (do_acc) begin
            if (legal(in_command)) begin
                e.c = in_command;
                e.a = (in_command == 4'd8 || in_command == 4'd9) ? 64'd0 : in_address;
                q.push_back(e);
            end else begin
                $display("%s drop illegal cmd=%0d", ph, in_command);
                if (ill_m != 32'hFFFF) ill_m++;
            end
        end
        if (in_last) eot_m = 1;
        done_m = done_nx;
        if (q.size() > 0) begin
            last_c = q[0].c;
            last_a = q[0].a;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [3:0] c, input logic [63:0] a);
        in_valid   = v;
        in_command = c;
        in_address = a;
    endtask

    initial begin
        logic [3:0] ill_list [3];
        rst_n = 1'b0;
        drive(0, 4'd0, 64'd0);
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single command, one-cycle latency through an empty FIFO
        out_ready = 1'b1;
        drive(1, 4'd0, 64'h1000);
        tick("t1");
        drive(0, 4'd0, 64'd0);
        tick("t1");
        tick("t1");

        // Illegal commands are consumed and counted but never stored
        ill_list[0] = 4'd5;
        ill_list[1] = 4'd7;
        ill_list[2] = 4'd12;
        for (int i = 0; i < 3; i++) begin
            drive(1, ill_list[i], 64'h2000 + 64'(i));
            tick("t2");
        end
        drive(0, 4'd0, 64'd0);
        tick("t2");
        chk("t2.illegal3", 64'(illegal_count), 64'd3);

        // Fill to full with the sink stalled; ninth command waits for a pop
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'(i % 5), 64'h3000 + 64'(i));
            tick("t3");
        end
        drive(1, 4'd1, 64'h3008);
        tick("t3");
        tick("t3");
        out_ready = 1'b1;
        tick("t3");
        out_ready = 1'b0;
        tick("t3");
        drive(0, 4'd0, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick("t3");

        // Clear / print carry a forced-zero address
        drive(1, 4'd8, 64'hDEADBEEF);
        tick("t4");
        drive(1, 4'd9, 64'h55);
        tick("t4");
        drive(0, 4'd0, 64'd0);
        for (int i = 0; i < 3; i++) tick("t4");

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            tick("rnd");
        end
        drive(0, 4'd0, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick("rnd");

        // End of trace: done only after the last buffered command is popped
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(i + 1), 64'h4000 + 64'(i));
            tick("t5");
        end
        drive(0, 4'd0, 64'd0);
        in_last = 1'b1;
        tick("t5");
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) tick("t5");
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick("t5");
        chk("t5.done_sticky", 64'(done), 64'd1);

        // Inputs after done are still accepted; then asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'd2, 64'h5000 + 64'(i));
            tick("t6");
        end
        drive(0, 4'd0, 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6.rst_in_ready",  64'(in_ready),      64'd1);
        chk("t6.rst_out_valid", 64'(out_valid),     64'd0);
        chk("t6.rst_out_cmd",   64'(out_command),   64'd0);
        chk("t6.rst_out_addr",  out_address,        64'd0);
        chk("t6.rst_out_op",    64'(out_op),        64'd0);
        chk("t6.rst_done",      64'(done),          64'd0);
        chk("t6.rst_illegal",   64'(illegal_count), 64'd0);
        chk("t6.rst_level",     64'(level),         64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("t6");
        out_ready = 1'b1;
        drive(1, 4'd4, 64'h6000);
        tick("t6");
        drive(0, 4'd0, 64'd0);
        for (int i = 0; i < 3; i++) tick("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
